// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST argmax/display stage.
//   state_e         : scan controller states
//   SEG_BLANK       : active-low pattern with every segment off
//   SEG_TABLE       : active-low {g,f,e,d,c,b,a} glyphs for 0..F
//   DEFAULT_CLASSES : number of class scores produced by the classifier
package mnist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned DEFAULT_CLASSES = 10;

  // Entry n is the glyph for hex digit n (entry 15 is written first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/mnist_argmax_display_hex7seg_decoder.sv
// Combinational hex digit to 7-segment decoder.
//   digit : 4-bit value to display
//   seg   : active-low segments {g,f,e,d,c,b,a}
module hex7seg_decoder
  import mnist_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/mnist_argmax_display.sv
// Registered argmax stage for the MNIST classifier output.
// Latches a vector of signed class scores on a res_valid pulse, scans it one
// score per cycle for the maximum, then presents the winning index, its
// score, a one-hot LED vector and a 7-segment glyph.
//   clk, reset : clock and synchronous active-high reset
//   res_valid  : one-cycle pulse, res_data holds a full result
//   res_data   : flattened scores, class k at [k*ACC_WIDTH +: ACC_WIDTH]
//   busy       : scan in progress, res_valid ignored
//   done       : one-cycle pulse when new outputs appear
//   ready      : outputs hold a valid result
//   class_idx  : index of the maximum score (lowest index on ties)
//   max_value  : maximum score, signed
//   classes    : one-hot of class_idx
//   hex        : active-low glyph of class_idx
module mnist_argmax_display
  import mnist_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned CLASSES   = DEFAULT_CLASSES,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         res_valid,
  input  logic [CLASSES*ACC_WIDTH-1:0] res_data,
  output logic                         busy,
  output logic                         done,
  output logic                         ready,
  output logic [IDX_W-1:0]             class_idx,
  output logic [ACC_WIDTH-1:0]         max_value,
  output logic [CLASSES-1:0]           classes,
  output logic [6:0]                   hex
);

  state_e state_q, state_d;

  logic [CLASSES*ACC_WIDTH-1:0] score_q, score_d;
  logic [ACC_WIDTH-1:0]         best_q, best_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [IDX_W-1:0]     class_idx_q, class_idx_d;
  logic [ACC_WIDTH-1:0] max_value_q, max_value_d;
  logic [CLASSES-1:0]   classes_q, classes_d;
  logic [6:0]           hex_q, hex_d;

  logic [ACC_WIDTH-1:0] cand;
  logic                 last_scan;
  logic [6:0]           seg_next;

  assign cand      = score_q[ptr_q*ACC_WIDTH +: ACC_WIDTH];
  assign last_scan = (ptr_q == IDX_W'(CLASSES - 1));

  // Decodes the post-compare winner so the glyph is ready on the final scan edge.
  hex7seg_decoder u_hex7seg_decoder (
    .digit (4'(best_idx_d)),
    .seg   (seg_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      class_idx_q <= '0;
      max_value_q <= '0;
      classes_q   <= '0;
      hex_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      class_idx_q <= class_idx_d;
      max_value_q <= max_value_d;
      classes_q   <= classes_d;
      hex_q       <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (res_valid) state_d = SCAN;
      SCAN:    if (last_scan) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Compare datapath: running maximum, strict greater-than keeps the lower index on ties.
  always_comb begin
    score_d    = score_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (res_valid) begin
          score_d    = res_data;
          best_d     = res_data[ACC_WIDTH-1:0];
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
        end
      end
      SCAN: begin
        if ($signed(cand) > $signed(best_q)) begin
          best_d     = cand;
          best_idx_d = ptr_q;
        end
        if (!last_scan) ptr_d = ptr_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Result registers load on the SCAN->DONE edge so they and done are visible
  // together during the DONE cycle.
  always_comb begin
    busy_d      = busy_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    class_idx_d = class_idx_q;
    max_value_d = max_value_q;
    classes_d   = classes_q;
    hex_d       = hex_q;
    unique case (state_q)
      IDLE: begin
        if (res_valid) begin
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SCAN: begin
        if (last_scan) begin
          done_d      = 1'b1;
          busy_d      = 1'b0;
          ready_d     = 1'b1;
          class_idx_d = best_idx_d;
          max_value_d = best_d;
          classes_d   = {{(CLASSES-1){1'b0}}, 1'b1} << best_idx_d;
          hex_d       = seg_next;
        end
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ready     = ready_q;
  assign class_idx = class_idx_q;
  assign max_value = max_value_q;
  assign classes   = classes_q;
  assign hex       = hex_q;

endmodule

// File: tb/tb_mnist_argmax_display.sv
// Self-checking bench for mnist_argmax_display: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_mnist_argmax_display;

  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned CLASSES   = 10;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned VW        = CLASSES*ACC_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 res_valid = 1'b0;
  logic [VW-1:0]        res_data = '0;
  logic                 busy, done, ready;
  logic [IDX_W-1:0]     class_idx;
  logic [ACC_WIDTH-1:0] max_value;
  logic [CLASSES-1:0]   classes;
  logic [6:0]           hex;

  always #5 clk = ~clk;

  mnist_argmax_display #(
    .ACC_WIDTH (ACC_WIDTH),
    .CLASSES   (CLASSES),
    .IDX_W     (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .ready     (ready),
    .class_idx (class_idx),
    .max_value (max_value),
    .classes   (classes),
    .hex       (hex)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic int argmax_of(input logic [VW-1:0] v);
    logic signed [ACC_WIDTH-1:0] best, s;
    int idx;
    best = v[ACC_WIDTH-1:0];
    idx = 0;
    for (int k = 1; k < CLASSES; k++) begin
      s = v[k*ACC_WIDTH +: ACC_WIDTH];
      if (s > best) begin
        best = s;
        idx = k;
      end
    end
    return idx;
  endfunction

  // Behavioural model: timeline of one accepted result, in cycles since accept.
  bit                   m_busy = 0, m_done = 0, m_ready = 0;
  int                   m_idx = 0;
  logic [ACC_WIDTH-1:0] m_max = '0;
  logic [CLASSES-1:0]   m_classes = '0;
  logic [6:0]           m_hex = 7'h7F;
  bit                   active = 0;
  int                   elapsed = 0;
  int                   p_idx = 0;
  logic [VW-1:0]        p_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_ready = 0; m_idx = 0; m_max = '0;
      m_classes = '0; m_hex = 7'h7F; active = 0; elapsed = 0;
    end else if (active) begin
      elapsed++;
      if (elapsed == CLASSES - 1) begin
        active = 0; m_busy = 0; m_done = 1; m_ready = 1;
        m_idx = p_idx;
        m_max = p_data[p_idx*ACC_WIDTH +: ACC_WIDTH];
        m_classes = '0;
        m_classes[p_idx] = 1'b1;
        m_hex = seg_of(p_idx);
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (res_valid) begin
      active = 1; elapsed = 0; m_busy = 1; m_ready = 0;
      p_data = res_data;
      p_idx = argmax_of(res_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      64'(busy),      64'(m_busy));
      chk("done",      64'(done),      64'(m_done));
      chk("ready",     64'(ready),     64'(m_ready));
      chk("class_idx", 64'(class_idx), 64'(m_idx));
      chk("max_value", 64'(max_value), 64'(m_max));
      chk("classes",   64'(classes),   64'(m_classes));
      chk("hex",       64'(hex),       64'(m_hex));
    end
  end

  task automatic send(input logic [VW-1:0] v);
    res_data  = v;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
  endtask

  function automatic logic [VW-1:0] fill(input logic [ACC_WIDTH-1:0] val);
    logic [VW-1:0] v;
    for (int k = 0; k < CLASSES; k++) v[k*ACC_WIDTH +: ACC_WIDTH] = val;
    return v;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] rnd_score();
    logic [ACC_WIDTH-1:0] s;
    case ($urandom % 3)
      0: s = $urandom;
      1: s = ACC_WIDTH'($urandom_range(0, 7)) - 32'd4;
      default: case ($urandom % 4)
        0: s = 32'h8000_0000;
        1: s = 32'h7FFF_FFFF;
        2: s = 32'h0;
        default: s = 32'hFFFF_FFFF;
      endcase
    endcase
    return s;
  endfunction

  initial begin
    logic [VW-1:0] v_clear, v_tie, v_min, v_first, v_last, v_other;
    int cyc;
    int vals [10] = '{5, -3, 12, 0, 7, 1, 2, 40, 9, -100};

    for (int k = 0; k < CLASSES; k++) v_clear[k*ACC_WIDTH +: ACC_WIDTH] = vals[k];
    v_tie = fill(-32'sd8);
    v_tie[2*ACC_WIDTH +: ACC_WIDTH] = -32'sd1;
    v_tie[5*ACC_WIDTH +: ACC_WIDTH] = -32'sd1;
    v_min = fill(32'h8000_0000);
    v_first = fill(32'd3);
    v_first[0 +: ACC_WIDTH] = 32'd100;
    v_last = fill(-32'sd50);
    v_last[9*ACC_WIDTH +: ACC_WIDTH] = 32'd7;
    v_other = fill(32'd0);
    v_other[3*ACC_WIDTH +: ACC_WIDTH] = 32'd1000;

    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_ready",   64'(ready),   64'd0);
    chk("rst_classes", 64'(classes), 64'd0);
    chk("rst_hex",     64'(hex),     64'h7F);
    reset = 1'b0;
    @(negedge clk);

    // Clear maximum
    send(v_clear);
    wait_done(cyc);
    chk("latency",      64'(cyc),       64'd10);
    chk("clr_idx",      64'(class_idx), 64'd7);
    chk("clr_max",      64'(max_value), 64'd40);
    chk("clr_classes",  64'(classes),   64'(10'b0010000000));
    chk("clr_hex",      64'(hex),       64'(7'b1111000));
    chk("clr_ready",    64'(ready),     64'd1);
    @(negedge clk);

    // Ties and negatives
    send(v_tie);
    wait_done(cyc);
    chk("tie_idx", 64'(class_idx), 64'd2);
    chk("tie_max", 64'(max_value), 64'(32'hFFFF_FFFF));
    @(negedge clk);
    send(v_min);
    wait_done(cyc);
    chk("min_idx", 64'(class_idx), 64'd0);
    chk("min_max", 64'(max_value), 64'(32'h8000_0000));
    @(negedge clk);

    // Boundaries
    send(v_first);
    wait_done(cyc);
    chk("first_idx", 64'(class_idx), 64'd0);
    chk("first_hex", 64'(hex),       64'(7'b1000000));
    @(negedge clk);
    send(v_last);
    wait_done(cyc);
    chk("last_idx", 64'(class_idx), 64'd9);
    chk("last_hex", 64'(hex),       64'(7'b0010000));
    @(negedge clk);

    // Back-to-back: pulse during scan is ignored, pulse after done is taken
    send(v_clear);
    repeat (2) @(negedge clk);
    send(v_other);
    wait_done(cyc);
    chk("b2b_idx", 64'(class_idx), 64'd7);
    @(negedge clk);
    send(v_first);
    chk("b2b_ready", 64'(ready), 64'd0);
    chk("b2b_busy",  64'(busy),  64'd1);
    wait_done(cyc);
    chk("b2b2_idx", 64'(class_idx), 64'd0);
    @(negedge clk);

    // Reset mid-scan
    send(v_clear);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy",  64'(busy),      64'd0);
    chk("mid_ready", 64'(ready),     64'd0);
    chk("mid_idx",   64'(class_idx), 64'd0);
    chk("mid_max",   64'(max_value), 64'd0);
    chk("mid_cls",   64'(classes),   64'd0);
    chk("mid_hex",   64'(hex),       64'h7F);
    repeat (12) begin
      @(negedge clk);
      chk("mid_nodone", 64'(done), 64'd0);
    end
    send(v_tie);
    wait_done(cyc);
    chk("post_idx", 64'(class_idx), 64'd2);
    @(negedge clk);

    // Randomized traffic, including pulses while busy/done and rare resets
    for (int n = 0; n < 3000; n++) begin
      logic [VW-1:0] v;
      for (int k = 0; k < CLASSES; k++) v[k*ACC_WIDTH +: ACC_WIDTH] = rnd_score();
      res_data  = v;
      res_valid = ($urandom % 4 == 0);
      reset     = ($urandom % 250 == 0);
      @(negedge clk);
    end
    res_valid = 1'b0;
    reset     = 1'b0;
    repeat (15) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mnist_argmax_display.md
Name: mnist_argmax_display

Overview:
- Downstream stage of the MNIST systolic-array wrapper.
- Accepts the 10 signed class scores of one inference as a single flattened vector with a one-cycle valid pulse.
- Serially scans the scores for the maximum, then drives the class index, a one-hot class vector for LEDR, an active-low 7-segment digit and a ready flag.
- Replaces ad-hoc argmax logic inside the wrapper with a registered, verifiable stage.

Parameters:
- ACC_WIDTH, 32, width of each signed class score.
- CLASSES, 10, number of scores per result. Legal range 2..16.
- IDX_W, 4, width of class index. Must satisfy 2**IDX_W >= CLASSES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- res_valid  in  1  one-cycle pulse: res_data holds a complete result.
- res_data  in  CLASSES*ACC_WIDTH  flattened signed scores; class k occupies bits [k*ACC_WIDTH +: ACC_WIDTH].
- busy  out  1  high while scanning; res_valid is ignored while busy.
- done  out  1  one-cycle pulse when new outputs are valid.
- ready  out  1  level: a valid result is held on the outputs.
- class_idx  out  IDX_W  index of the maximum score.
- max_value  out  ACC_WIDTH  maximum score, signed.
- classes  out  CLASSES  one-hot of class_idx.
- hex  out  7  active-low segments {g,f,e,d,c,b,a} showing class_idx.

Behaviour:
- Single clock (clk); reset is synchronous and active-high (reset). Every output register is updated on the rising clk edge.
- Reset values: busy=0, done=0, ready=0, class_idx=0, max_value=0, classes=0, hex=7'h7F (blank). State = IDLE.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On res_valid=1: latch res_data into an internal score register.
  - Set best=score[0], best_idx=0, scan pointer i=1, busy=1, ready=0. Go to SCAN.
  - Outputs from any previous result stay held until DONE; only ready drops.
- SCAN: each cycle compares score[i] against best using a signed comparison.
  - Strictly greater: replace best and best_idx. Ties keep the lower index.
  - If i==CLASSES-1, go to DONE; otherwise i++.
  - res_valid is ignored in SCAN.
- DONE (one cycle):
  - Register class_idx=best_idx, max_value=best, classes=1<<best_idx, hex=decode(best_idx).
  - done=1 for exactly this cycle, ready=1, busy=0. Next state is IDLE.
  - res_valid in the DONE cycle is ignored.
- Latency:
  - res_valid sampled at edge E0; done and the new outputs are visible in the cycle after edge E(CLASSES-1).
  - For CLASSES=10, done is high 10 cycles after the res_valid cycle.
  - The earliest next accept is the cycle after done.
- ready stays 1 until the next accepted res_valid or reset.
- Reset during SCAN or DONE: abort immediately and return to reset values. No done pulse is generated.
- Scores are compared as full-width two's complement with no truncation. Edge cases:
  - All-equal scores give index 0.
  - The most negative value is handled correctly.
- hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Package mnist_pkg:
  - state enum {IDLE, SCAN, DONE}.
  - localparam SEG_BLANK = 7'h7F.
  - 16-entry segment constant array used by the decoder.
  - Default CLASSES=10.
- Sub-module hex7seg_decoder: purely combinational, 4-bit in, 7-bit active-low out, table taken from mnist_pkg. It is instantiated on best_idx and its output is registered into hex in DONE.

Test Plan:
- Reset behaviour: assert reset for 2 cycles -> busy=0, done=0, ready=0, classes=0, hex=7'h7F.
- Clear maximum: scores {5,-3,12,0,7,1,2,40,9,-100}, one res_valid -> done exactly 10 cycles later; class_idx=7, max_value=40, classes=10'b0010000000, hex=7'b1111000, ready=1.
- Ties and negatives:
  - All scores -8 except scores[2]=scores[5]=-1 -> class_idx=2, max_value=-1.
  - All scores 0x80000000 -> class_idx=0.
- Boundaries: max at index 0 -> class_idx=0, hex=7'b1000000. Max at index 9 -> class_idx=9, hex=7'b0010000.
- Back-to-back inputs: second res_valid pulsed 3 cycles into a scan with a different maximum -> ignored; a single done with the first result. A res_valid the cycle after done is accepted and ready drops.
- Reset mid-scan: reset asserted 5 cycles into SCAN -> no done pulse; all outputs return to reset values. A subsequent res_valid completes normally.
